// File: rtl/scaler_line_pack_pkg.sv
// rtl/scaler_line_pack_pkg.sv - shared types and build constants for scaler_line_pack
// SCALER_LINE_PACK_PAD_EN selects padding of hs-terminated short lines.
package scaler_line_pack_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_t;

  typedef logic bank_t;

`ifdef SCALER_LINE_PACK_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

endpackage

// File: rtl/scaler_line_pack_ram.sv
// rtl/scaler_line_pack_ram.sv - simple dual-port line buffer, one write port, one registered read port
module scaler_line_pack_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scaler_line_pack.sv
// rtl/scaler_line_pack.sv - ping-pong line packer: sparse scaler pixels in, dense valid/ready lines out
// Build option SCALER_LINE_PACK_PAD_EN: short lines are replayed at line_width, repeating the last pixel.
module scaler_line_pack
  import scaler_line_pack_pkg::*;
#(
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH:0]    line_width,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  input  logic                   rdy_i,
  output logic                   ovf_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] MAX_LEN = ONE << ADDR_WIDTH;

  logic [1:0]    bank_full, bank_vs;
  logic [CW-1:0] bank_cnt [2];
  logic [CW-1:0] bank_len [2];

  bank_t         wr_bank, wr_bank_n, tgt;
  logic [CW-1:0] wr_cnt, wr_cnt_n, lw_q, lw_n, lw_in;
  logic          wr_active, wr_active_n, ovf_set;
  logic [1:0]    commit, vs_load;
  logic [CW-1:0] commit_cnt [2];
  logic [CW-1:0] commit_len [2];
  logic          ram_we;
  logic [ADDR_WIDTH:0] ram_waddr;

  assign lw_in = (line_width > MAX_LEN) ? MAX_LEN : line_width;

  // An hs closes any partial line, then opens the next bank in commit order.
  always_comb begin
    wr_bank_n     = wr_bank;
    wr_cnt_n      = wr_cnt;
    wr_active_n   = wr_active;
    lw_n          = lw_q;
    tgt           = wr_bank;
    ovf_set       = 1'b0;
    commit        = '0;
    vs_load       = '0;
    commit_cnt[0] = '0;
    commit_cnt[1] = '0;
    commit_len[0] = '0;
    commit_len[1] = '0;
    ram_we        = 1'b0;
    ram_waddr     = '0;
    if (de_i && hs_i) begin
      lw_n        = lw_in;
      wr_active_n = 1'b0;
      wr_cnt_n    = '0;
      if (wr_active && wr_cnt != '0) begin
        commit[wr_bank]     = 1'b1;
        commit_cnt[wr_bank] = wr_cnt;
        commit_len[wr_bank] = PAD_EN ? lw_q : wr_cnt;
        tgt                 = ~wr_bank;
      end
      wr_bank_n = tgt;
      if (lw_in != '0) begin
        if (bank_full[tgt]) begin
          ovf_set = 1'b1;
        end else begin
          ram_we       = 1'b1;
          ram_waddr    = {tgt, ADDR_WIDTH'(0)};
          vs_load[tgt] = 1'b1;
          if (lw_in == ONE) begin
            commit[tgt]     = 1'b1;
            commit_cnt[tgt] = ONE;
            commit_len[tgt] = ONE;
            wr_bank_n       = ~tgt;
          end else begin
            wr_active_n = 1'b1;
            wr_cnt_n    = ONE;
          end
        end
      end
    end else if (de_i && wr_active) begin
      ram_we    = 1'b1;
      ram_waddr = {wr_bank, wr_cnt[ADDR_WIDTH-1:0]};
      if (wr_cnt + ONE == lw_q) begin
        commit[wr_bank]     = 1'b1;
        commit_cnt[wr_bank] = lw_q;
        commit_len[wr_bank] = lw_q;
        wr_active_n         = 1'b0;
        wr_cnt_n            = '0;
        wr_bank_n           = ~wr_bank;
      end else begin
        wr_cnt_n = wr_cnt + ONE;
      end
    end
  end

  rd_state_t     state, state_n;
  bank_t         rd_bank;
  logic [CW-1:0] rd_idx, rd_idx_n, issue_idx, cur_cnt, cur_len;
  logic [ADDR_WIDTH-1:0]  rd_pos;
  logic          issue, release_bank, out_free, can_issue;
  logic          v1, hs1, vs1, last1, last_o;
  logic [PIXEL_WIDTH-1:0] ram_rdata;

  assign cur_cnt   = bank_cnt[rd_bank];
  assign cur_len   = bank_len[rd_bank];
  assign out_free  = !de_o || rdy_i;
  assign can_issue = !v1 || out_free;
  assign issue_idx = (state == ST_IDLE) ? '0 : rd_idx;
  // Positions beyond the stored count (padding) re-read the last written pixel.
  assign rd_pos    = ADDR_WIDTH'((issue_idx >= cur_cnt) ? cur_cnt - ONE : issue_idx);

  always_comb begin
    state_n      = state;
    rd_idx_n     = rd_idx;
    issue        = 1'b0;
    release_bank = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bank_full[rd_bank] && can_issue) begin
          issue    = 1'b1;
          rd_idx_n = ONE;
          state_n  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_idx < cur_len && can_issue) begin
          issue    = 1'b1;
          rd_idx_n = rd_idx + ONE;
        end
        if (de_o && rdy_i && last_o) begin
          release_bank = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= '0;
      wr_cnt    <= '0;
      wr_active <= 1'b0;
      lw_q      <= '0;
      ovf_o     <= 1'b0;
      bank_full <= '0;
      bank_vs   <= '0;
      for (int b = 0; b < 2; b++) begin
        bank_cnt[b] <= '0;
        bank_len[b] <= '0;
      end
    end else begin
      wr_bank   <= wr_bank_n;
      wr_cnt    <= wr_cnt_n;
      wr_active <= wr_active_n;
      lw_q      <= lw_n;
      if (ovf_set) ovf_o <= 1'b1;
      else if (de_i && vs_i) ovf_o <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        if (release_bank && rd_bank == bank_t'(b)) bank_full[b] <= 1'b0;
        if (commit[b]) begin
          bank_full[b] <= 1'b1;
          bank_cnt[b]  <= commit_cnt[b];
          bank_len[b]  <= commit_len[b];
        end
        if (vs_load[b]) bank_vs[b] <= vs_i;
      end
    end
  end

  // Read stage and output register stall together so the RAM output holds while blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rd_bank <= '0;
      rd_idx  <= '0;
      v1      <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      last1   <= 1'b0;
      do_o    <= '0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      state  <= state_n;
      rd_idx <= rd_idx_n;
      if (release_bank) rd_bank <= ~rd_bank;
      if (can_issue) begin
        v1    <= issue;
        hs1   <= issue && (issue_idx == '0);
        vs1   <= issue && (issue_idx == '0) && bank_vs[rd_bank];
        last1 <= issue && (issue_idx == cur_len - ONE);
      end
      if (out_free) begin
        de_o   <= v1;
        hs_o   <= v1 && hs1;
        vs_o   <= v1 && vs1;
        last_o <= v1 && last1;
        if (v1) do_o <= ram_rdata;
      end
    end
  end

  scaler_line_pack_ram #(
    .DATA_WIDTH(PIXEL_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (di_i),
    .re    (issue),
    .raddr ({rd_bank, rd_pos}),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/scaler_line_pack.md
# scaler_line_pack

Receiver for the horizontal scaler's output stream. Accepts sparse pixels (de/hs/vs, hs and vs qualified by de on the first pixel of a line/frame) and collects each line into a ping-pong line buffer. Replays every committed line as a dense, back-pressurable burst using the same de/hs/vs marking. Sits between the horizontal scaler and the vertical scaler / output timing stages.

## Interface
- PIXEL_WIDTH, 12, pixel data width
- ADDR_WIDTH, 11, line buffer address width; max line 2^ADDR_WIDTH pixels
- clk  in  1  clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- line_width  in  ADDR_WIDTH+1  expected output pixels per line; sampled at each line start
- di_i  in  PIXEL_WIDTH  input pixel
- de_i  in  1  input pixel valid (sparse)
- hs_i  in  1  first pixel of line, valid only with de_i
- vs_i  in  1  first pixel of frame, valid only with de_i
- do_o  out  PIXEL_WIDTH  output pixel
- de_o  out  1  output valid
- hs_o  out  1  first pixel of output line, with de_o
- vs_o  out  1  first pixel of output frame, with de_o
- rdy_i  in  1  downstream ready
- ovf_o  out  1  sticky overflow; cleared on accepted de_i&&vs_i

## Operation
- Two banks, each with: full flag, stored count, stored vs flag.
- Write side: wr_cnt counts pixels written into current write bank.
  - de_i&&hs_i: if wr_cnt>0, commit current bank; new pixel goes to other bank, address 0. Sample line_width; store vs_i as bank vs flag.
  - de_i without hs_i: write at wr_cnt, increment. Pixels once wr_cnt==line_width: discarded, no error.
  - wr_cnt reaching line_width: commit bank on that write cycle.
  - Target bank still full when a line must start: all pixels of that line discarded, ovf_o set.
  - line_width==0: all input discarded, nothing committed, ovf_o unaffected.
  - Pixels with de_i before first hs_i after reset: discarded.
- Read FSM: IDLE, RUN.
  - IDLE: oldest full bank (commit order) -> RUN, rd_addr=0.
  - RUN: emit stored count pixels; hs_o on pixel 0; vs_o on pixel 0 if bank vs flag set. After last pixel accepted, clear bank full, -> IDLE.
- Handshake: valid/ready. Once de_o=1, do_o/hs_o/vs_o stay stable until cycle with rdy_i=1. Transfer = de_o&&rdy_i.
- Commit and release of same bank in same cycle: release wins first, bank usable next cycle.

## Timing
- Reset values: do_o=0, de_o=0, hs_o=0, vs_o=0, ovf_o=0; banks empty, FSM IDLE, wr_cnt=0.
- Line buffer read latency 1 clock; output registered.
- Commit cycle N -> first de_o at N+3 with rdy_i high.
- Throughput: 1 pixel/clk while rdy_i=1 within a line; de_o gap between consecutive lines at most 3 clocks.
- rdy_i low: no pixel lost or duplicated; output resumes next cycle after rdy_i returns.
- Async reset mid-line: all state cleared immediately; partial lines lost.

## Configuration
- SCALER_LINE_PACK_PAD_EN defined: line committed by hs with count<line_width is emitted as exactly line_width pixels; positions >= count repeat last written pixel.
- Undefined: short line emitted at stored count.

## Structure
- Package scaler_line_pack_pkg: FSM state enum (IDLE, RUN), bank index type, PAD default constants.
- Sub-module scaler_line_pack_ram: simple dual-port RAM, one write port, one registered read port, 2*2^ADDR_WIDTH words (bank bit as address MSB).

## Test plan
- line_width=4, one line of 4 sparse pixels 10,20,30,40 (gaps 2 clk), rdy_i=1 -> dense 10,20,30,40, hs_o on 10, first de_o 3 clk after 4th write.
- vs_i on first pixel of frame, two lines width 3 -> vs_o only with first output pixel; hs_o on pixel 0 of each line.
- line_width=4, hs after 2 pixels 5,6 -> without PAD_EN: 5,6; with PAD_EN: 5,6,6,6.
- rdy_i held low, three lines input -> lines 1,2 buffered, line 3 discarded, ovf_o=1; rdy_i high -> lines 1,2 emitted intact; next de_i&&vs_i clears ovf_o.
- rdy_i toggled every cycle during line 1,2,3,4,5 -> output exactly 1..5, data stable during stalls.
- Assert rst_n low mid-burst -> all outputs 0 same cycle; after release, next full line emitted normally.
